// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its forwarding muxes.
// Widths, ALU mode encodings and the bubble control word live here.
package id_ex_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_NOT  = 2'b01,
        ALU_PASS = 2'b10,
        ALU_NOP  = 2'b11
    } alu_mode_e;

    typedef struct packed {
        logic      valid;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        alu_mode_e alu_mode;
    } ex_ctrl_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
    } ex_data_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_mode:  ALU_NOP
    };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: youngest producer (EX/MEM) wins over MEM/WB, else register data.
// Register 0 is forwarded like any other register.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_valid,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] operand
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_valid & exm_reg_write & (exm_rd == rs);
    assign mwb_hit = mwb_valid & mwb_reg_write & (mwb_rd == rs);

    always_comb begin
        operand = reg_data;
        if (exm_hit) begin
            operand = exm_result;
        end else if (mwb_hit) begin
            operand = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit ALU: captures decoded fields, inserts bubbles on
// flush or load-use hazard, and forwards operands combinationally into execute.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_uses_rs2,
    input  logic [1:0]        id_alu_mode,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_valid,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [1:0]        ex_alu_mode,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              hazard_stall
);

    ex_ctrl_t ctrl_q, ctrl_d;
    ex_data_t data_q, data_d;
    logic     load_use;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    // A load sitting in EX cannot forward in time to the instruction in ID.
    assign load_use = id_valid & ctrl_q.valid & ctrl_q.mem_read &
                      ((data_q.rd == id_rs1) | (id_uses_rs2 & (data_q.rd == id_rs2)));

    // Upstream holds IF/ID for every cycle this is high; flush overrides it.
    assign hazard_stall = load_use & ~flush;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (flush) begin
            ctrl_d = BUBBLE_CTRL;
        end else if (!stall) begin
            if (load_use) begin
                ctrl_d = BUBBLE_CTRL;
            end else begin
                ctrl_d.valid     = id_valid;
                ctrl_d.reg_write = id_reg_write;
                ctrl_d.mem_read  = id_mem_read;
                ctrl_d.mem_write = id_mem_write;
                ctrl_d.alu_mode  = alu_mode_e'(id_alu_mode);
                data_d.rd        = id_rd;
                data_d.rs1       = id_rs1;
                data_d.rs2       = id_rs2;
                data_d.rs1_data  = id_rs1_data;
                data_d.rs2_data  = id_rs2_data;
                data_d.imm       = id_imm;
                data_d.use_imm   = id_use_imm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= BUBBLE_CTRL;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs            (data_q.rs1),
        .reg_data      (data_q.rs1_data),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_valid     (mwb_valid),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .operand       (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs            (data_q.rs2),
        .reg_data      (data_q.rs2_data),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_valid     (mwb_valid),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .operand       (fwd_rs2)
    );

    assign ex_op1        = fwd_rs1;
    assign ex_op2        = data_q.use_imm ? data_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_alu_mode   = ctrl_q.alu_mode;
    assign ex_rd         = data_q.rd;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a behavioural model of the EX-stage instruction,
// plus directed scenarios for reset, forwarding priority, load-use, stall and flush.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_uses_rs2;
    logic [1:0]  id_alu_mode;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic        exm_valid, exm_reg_write;
    logic [2:0]  exm_rd;
    logic [15:0] exm_result;
    logic        mwb_valid, mwb_reg_write;
    logic [2:0]  mwb_rd;
    logic [15:0] mwb_result;
    logic [15:0] ex_op1, ex_op2, ex_store_data;
    logic [1:0]  ex_alu_mode;
    logic [2:0]  ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        hazard_stall;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the instruction currently occupying EX
    logic        m_valid, m_rw, m_mr, m_mw;
    logic [1:0]  m_mode;
    logic [2:0]  m_rd, m_rs1, m_rs2;
    logic [15:0] m_d1, m_d2, m_imm;
    logic        m_use_imm;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rs2(id_uses_rs2), .id_alu_mode(id_alu_mode),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_result(exm_result),
        .mwb_valid(mwb_valid), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
        .mwb_result(mwb_result),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_alu_mode(ex_alu_mode), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
        .hazard_stall(hazard_stall)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] fwd_ref(input logic [2:0] rs, input logic [15:0] regval);
        if (exm_valid && exm_reg_write && exm_rd == rs) return exm_result;
        if (mwb_valid && mwb_reg_write && mwb_rd == rs) return mwb_result;
        return regval;
    endfunction

    function automatic logic exp_hazard();
        return !flush && id_valid && m_valid && m_mr &&
               ((m_rd == id_rs1) || (id_uses_rs2 && m_rd == id_rs2));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mode = 2'b11;
        m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_use_imm = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mode = 2'b11;
    endtask

    // driver tasks
    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_use_imm = 0; id_uses_rs2 = 0; id_alu_mode = 2'b11;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        stall = 0; flush = 0;
        exm_valid = 0; exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_valid = 0; mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    task automatic drive_id(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] mode,
                            input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = 16'h0; id_use_imm = 0;
        id_uses_rs2 = 1; id_alu_mode = mode; id_reg_write = 1;
        id_mem_read = mr; id_mem_write = 0;
    endtask

    task automatic drive_random_id();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_rs1       = 3'($urandom_range(0, 7));
        id_rs2       = 3'($urandom_range(0, 7));
        id_rd        = 3'($urandom_range(0, 7));
        id_rs1_data  = 16'($urandom);
        id_rs2_data  = 16'($urandom);
        id_imm       = 16'($urandom);
        id_use_imm   = 1'($urandom_range(0, 1));
        id_uses_rs2  = 1'($urandom_range(0, 1));
        id_alu_mode  = 2'($urandom_range(0, 3));
        id_reg_write = 1'($urandom_range(0, 1));
        id_mem_read  = ($urandom_range(0, 1) == 0);
        id_mem_write = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drive_random();
        drive_random_id();
        stall         = ($urandom_range(0, 4) == 0);
        flush         = ($urandom_range(0, 9) == 0);
        exm_valid     = 1'($urandom_range(0, 1));
        exm_reg_write = 1'($urandom_range(0, 1));
        exm_rd        = 3'($urandom_range(0, 7));
        exm_result    = 16'($urandom);
        mwb_valid     = 1'($urandom_range(0, 1));
        mwb_reg_write = 1'($urandom_range(0, 1));
        mwb_rd        = 3'($urandom_range(0, 7));
        mwb_result    = 16'($urandom);
    endtask

    // scoreboard: compare every observable output with the model
    task automatic settle();
        logic [15:0] f1, f2;
        #1;
        f1 = fwd_ref(m_rs1, m_d1);
        f2 = fwd_ref(m_rs2, m_d2);
        check("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_rw});
        check("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m_mr});
        check("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_mw});
        check("ex_alu_mode", {30'b0, ex_alu_mode}, {30'b0, m_mode});
        check("hazard_stall", {31'b0, hazard_stall}, {31'b0, exp_hazard()});
        if (m_valid) begin
            check("ex_rd", {29'b0, ex_rd}, {29'b0, m_rd});
            check("ex_op1", {16'b0, ex_op1}, {16'b0, f1});
            check("ex_op2", {16'b0, ex_op2}, {16'b0, m_use_imm ? m_imm : f2});
            check("ex_store_data", {16'b0, ex_store_data}, {16'b0, f2});
        end
    endtask

    task automatic advance();
        logic hz;
        hz = exp_hazard();
        @(posedge clk);
        if (flush || (!stall && hz)) begin
            model_bubble();
        end else if (!stall) begin
            m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
            m_mode = id_alu_mode; m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_use_imm = id_use_imm;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    logic [15:0] s_op1, s_op2;
    logic [2:0]  s_rd;
    logic [1:0]  s_mode;

    initial begin
        clear_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        settle();
        check("reset_ex_rd", {29'b0, ex_rd}, 32'd0);
        check("reset_op1", {16'b0, ex_op1}, 32'd0);
        rst = 0;

        // Load ADD r1=5, r2=7
        drive_id(3'd1, 3'd2, 3'd6, 16'd5, 16'd7, 2'b00, 1'b0);
        advance();
        id_valid = 0;
        settle();
        check("t2_op1", {16'b0, ex_op1}, 32'd5);
        check("t2_op2", {16'b0, ex_op2}, 32'd7);
        check("t2_mode", {30'b0, ex_alu_mode}, 32'd0);
        check("t2_rd", {29'b0, ex_rd}, 32'd6);
        check("t2_valid", {31'b0, ex_valid}, 32'd1);

        // Forwarding priority on rs1 = r3
        drive_id(3'd3, 3'd4, 3'd5, 16'h1111, 16'h2222, 2'b00, 1'b0);
        advance();
        id_valid = 0;
        exm_valid = 1; exm_reg_write = 1; exm_rd = 3'd3; exm_result = 16'h00AA;
        mwb_valid = 1; mwb_reg_write = 1; mwb_rd = 3'd3; mwb_result = 16'h0055;
        settle();
        check("t3_exm_wins", {16'b0, ex_op1}, 32'h00AA);
        exm_valid = 0;
        settle();
        check("t3_mwb", {16'b0, ex_op1}, 32'h0055);
        mwb_valid = 0;
        settle();
        check("t3_reg", {16'b0, ex_op1}, 32'h1111);

        // Load-use: load to r2 in EX, ADD reading r2 in ID
        drive_id(3'd0, 3'd0, 3'd2, 16'h0, 16'h0, 2'b00, 1'b1);
        advance();
        drive_id(3'd2, 3'd1, 3'd7, 16'h0009, 16'h0003, 2'b00, 1'b0);
        settle();
        check("t4_hazard", {31'b0, hazard_stall}, 32'd1);
        advance();
        settle();
        check("t4_bubble", {31'b0, ex_valid}, 32'd0);
        check("t4_hazard_clear", {31'b0, hazard_stall}, 32'd0);
        advance();
        settle();
        check("t4_add_in", {31'b0, ex_valid}, 32'd1);

        // Stall three cycles with changing ID
        s_op1 = ex_op1; s_op2 = ex_op2; s_rd = ex_rd; s_mode = ex_alu_mode;
        for (int i = 0; i < 3; i++) begin
            drive_random_id();
            id_valid = 1; id_mem_read = 0;
            stall = 1;
            advance();
            settle();
            check("t5_hold_op1", {16'b0, ex_op1}, {16'b0, s_op1});
            check("t5_hold_op2", {16'b0, ex_op2}, {16'b0, s_op2});
            check("t5_hold_rd", {29'b0, ex_rd}, {29'b0, s_rd});
            check("t5_hold_mode", {30'b0, ex_alu_mode}, {30'b0, s_mode});
        end
        stall = 0;
        drive_id(3'd5, 3'd6, 3'd4, 16'h1234, 16'h4321, 2'b10, 1'b0);
        advance();
        settle();
        check("t5_release_rd", {29'b0, ex_rd}, 32'd4);
        check("t5_release_op1", {16'b0, ex_op1}, 32'h1234);

        // Flush with stall, then flush during hazard
        drive_id(3'd1, 3'd1, 3'd3, 16'h1, 16'h1, 2'b00, 1'b0);
        id_mem_write = 1;
        flush = 1; stall = 1;
        advance();
        flush = 0; stall = 0; id_valid = 0;
        settle();
        check("t6_valid", {31'b0, ex_valid}, 32'd0);
        check("t6_mode", {30'b0, ex_alu_mode}, 32'd3);
        check("t6_rw", {31'b0, ex_reg_write}, 32'd0);
        check("t6_mw", {31'b0, ex_mem_write}, 32'd0);
        drive_id(3'd0, 3'd0, 3'd4, 16'h0, 16'h0, 2'b00, 1'b1);
        advance();
        drive_id(3'd4, 3'd0, 3'd1, 16'h0, 16'h0, 2'b00, 1'b0);
        flush = 1;
        settle();
        check("t6_flush_hazard", {31'b0, hazard_stall}, 32'd0);
        flush = 0;
        settle();
        check("t6_hazard_back", {31'b0, hazard_stall}, 32'd1);
        advance();

        // Randomized traffic with a mid-stream async reset
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            if (i == 1500) begin
                settle();
                #2 rst = 1;
                model_reset();
                exm_valid = 0; mwb_valid = 0;
                #1;
                check("t1_valid", {31'b0, ex_valid}, 32'd0);
                check("t1_mode", {30'b0, ex_alu_mode}, 32'd3);
                check("t1_hazard", {31'b0, hazard_stall}, 32'd0);
                check("t1_op1", {16'b0, ex_op1}, 32'd0);
                @(negedge clk);
                rst = 0;
                drive_random();
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
